// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency data-memory port between two requesters
module mem_port_arbiter #(
    parameter int XLEN = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_we,
    input  logic [XLEN-1:0] req0_addr,
    input  logic [XLEN-1:0] req0_wdata,
    output logic            req0_rvalid,
    output logic [XLEN-1:0] req0_rdata,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_we,
    input  logic [XLEN-1:0] req1_addr,
    input  logic [XLEN-1:0] req1_wdata,
    output logic            req1_rvalid,
    output logic [XLEN-1:0] req1_rdata,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            grant_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
    state_t state, state_nx;
    logic last_served, sel, hs, cap, lat_we;
    logic [3:0] cnt;
    logic [XLEN-1:0] lat_addr, lat_wdata, rdata0, rdata1;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        sel = (req0_valid && req1_valid) ? ~last_served : req1_valid;
        hs = !rst && state == IDLE && (req0_valid || req1_valid);
        cap = state == ACCESS && cnt == 4'd0;
        state_nx = state == IDLE ? (hs ? ACCESS : IDLE) : state == ACCESS ? (cap ? DONE : ACCESS) : IDLE;
        req0_ready = hs && !sel;
        req1_ready = hs && sel;
        req0_rvalid = !rst && state == DONE && !grant_id;
        req1_rvalid = !rst && state == DONE && grant_id;
        // the counter still holds its load value only on the first ACCESS cycle
        mem_write_en = !rst && state == ACCESS && lat_we && cnt == CNT_INIT;
        mem_addr = rst ? '0 : lat_addr;
        mem_wdata = rst ? '0 : lat_wdata;
        req0_rdata = rdata0;
        req1_rdata = rdata1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= 1'b1;
            cnt <= 4'd0;
            lat_addr <= '0;
            lat_wdata <= '0;
            lat_we <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
            grant_id <= 1'b0;
        end else begin
            if (hs) begin
                lat_addr <= sel ? req1_addr : req0_addr;
                lat_wdata <= sel ? req1_wdata : req0_wdata;
                lat_we <= sel ? req1_we : req0_we;
                grant_id <= sel;
                cnt <= CNT_INIT;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (cap && !grant_id) rdata0 <= lat_we ? '0 : mem_rdata;
            if (cap && grant_id) rdata1 <= lat_we ? '0 : mem_rdata;
            if (state == DONE) last_served <= grant_id;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a transaction-level arbiter model
module tb_mem_port_arbiter;
    localparam int L = 2;
    logic clk = 1'b0, rst;
    logic v0, rdy0, we0, rv0, v1, rdy1, we1, rv1, mwe, gid;
    logic [31:0] a0, wd0, rd0, a1, wd1, rd1, maddr, mwd, mrd;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic s_rst, s_v, s_rdy, s_rv, s_mwe, s_r1rdy, s_r1rv, s_gid;
    logic [31:0] s_a, s_rd, s_maddr, s_mwd, s_mrd, s_r1rd;
    int cyc, nf, rv_c, hs_c, total, passes, ng;
    logic last, gp, gwe, exp_gid, pg;
    logic [31:0] gaddr, lat_a, lat_d;
    logic [31:0] exp_rd [2];
    logic [1:0] acc;
    logic [5:0] rdy_pat, rv_pat;

    always #5 clk = ~clk;
    assign mrd = mem[maddr[5:2]];
    assign s_mrd = s_maddr == 32'd0 ? 32'hA : s_maddr == 32'd4 ? 32'hB : 32'hF;

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(rdy0), .req0_we(we0), .req0_addr(a0), .req0_wdata(wd0),
        .req0_rvalid(rv0), .req0_rdata(rd0),
        .req1_valid(v1), .req1_ready(rdy1), .req1_we(we1), .req1_addr(a1), .req1_wdata(wd1),
        .req1_rvalid(rv1), .req1_rdata(rd1),
        .mem_addr(maddr), .mem_wdata(mwd), .mem_write_en(mwe), .mem_rdata(mrd), .grant_id(gid)
    );

    mem_port_arbiter #(.XLEN(32), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(s_rst),
        .req0_valid(s_v), .req0_ready(s_rdy), .req0_we(1'b0), .req0_addr(s_a), .req0_wdata(32'd0),
        .req0_rvalid(s_rv), .req0_rdata(s_rd),
        .req1_valid(1'b0), .req1_ready(s_r1rdy), .req1_we(1'b0), .req1_addr(32'd0), .req1_wdata(32'd0),
        .req1_rvalid(s_r1rv), .req1_rdata(s_r1rd),
        .mem_addr(s_maddr), .mem_wdata(s_mwd), .mem_write_en(s_mwe), .mem_rdata(s_mrd), .grant_id(s_gid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One cycle: predict from the arbitration rules, compare, then advance the model.
    task automatic tick();
        logic sel, idle;
        logic [1:0] er;
        idle = !rst && cyc >= nf;
        sel = (v0 && v1) ? !last : v1;
        er = 2'b00;
        if (idle && (v0 || v1)) er[sel] = 1'b1;
        if (cyc == rv_c) exp_rd[gp] = gwe ? 32'd0 : ref_mem[gaddr[5:2]];
        #1;
        chk("ready0", 32'(rdy0), 32'(er[0]));
        chk("ready1", 32'(rdy1), 32'(er[1]));
        chk("rvalid0", 32'(rv0), 32'(!rst && cyc == rv_c && !gp));
        chk("rvalid1", 32'(rv1), 32'(!rst && cyc == rv_c && gp));
        chk("mem_write_en", 32'(mwe), 32'(!rst && cyc == hs_c + 1 && gwe));
        chk("mem_addr", maddr, rst ? 32'd0 : lat_a);
        chk("mem_wdata", mwd, rst ? 32'd0 : lat_d);
        if (!rst) begin
            chk("rdata0", rd0, exp_rd[0]);
            chk("rdata1", rd1, exp_rd[1]);
            chk("grant_id", 32'(gid), 32'(exp_gid));
        end
        acc = er;
        if (mwe) mem[maddr[5:2]] = mwd;
        if (rst) begin
            nf = cyc + 1; last = 1'b1; rv_c = -100; hs_c = -100; gwe = 1'b0;
            exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; exp_gid = 1'b0; lat_a = 32'd0; lat_d = 32'd0;
        end else begin
            if (cyc == hs_c + 1 && gwe) ref_mem[gaddr[5:2]] = lat_d;
            if (|er) begin
                hs_c = cyc; gp = sel; gwe = sel ? we1 : we0; gaddr = sel ? a1 : a0;
                lat_a = gaddr; lat_d = sel ? wd1 : wd0;
                rv_c = cyc + L + 1; nf = cyc + L + 2; last = sel; exp_gid = sel;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        total = 0; passes = 0; cyc = 0; nf = 0; rv_c = -100; hs_c = -100;
        last = 1'b1; gp = 1'b0; gwe = 1'b0; exp_gid = 1'b0; gaddr = 0; lat_a = 0; lat_d = 0;
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0; acc = 2'b00;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        s_rst = 1'b1; s_v = 1'b0; s_a = 32'd0;
        rst = 1'b1; v0 = 1'b1; v1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
        a0 = 32'h4; a1 = 32'h8; wd0 = 32'h55; wd1 = 32'h66;
        @(negedge clk);
        repeat (2) tick();
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        tick();
        // req0 read of 0x10
        v0 = 1'b1; we0 = 1'b0; a0 = 32'h10;
        tick();
        chk("read_accepted", 32'(acc), 32'h1);
        v0 = 1'b0;
        repeat (4) tick();
        chk("read_deadbeef", rd0, 32'hDEADBEEF);
        // req1 write of 0x11223344 to 0x20
        v1 = 1'b1; we1 = 1'b1; a1 = 32'h20; wd1 = 32'h11223344;
        tick();
        v1 = 1'b0;
        repeat (4) tick();
        chk("write_landed", mem[8], 32'h11223344);
        chk("write_ack_rdata", rd1, 32'd0);
        // both valid continuously from reset
        rst = 1'b1;
        tick();
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; we0 = 1'b0; we1 = 1'b0; ng = 0; pg = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (|acc) begin
                chk("alternate", 32'(acc[1]), 32'(!pg));
                pg = acc[1];
                ng++;
            end
        end
        chk("grants_in_16", ng, 4);
        // reset during the second ACCESS cycle of a req0 read
        v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        v0 = 1'b1; a0 = 32'h8;
        tick();
        v0 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
        tick();
        chk("post_reset_grant0", 32'(acc), 32'h1);
        v0 = 1'b0; v1 = 1'b0;
        repeat (5) tick();
        // req0 pulse while port 1 is being served
        v1 = 1'b1; we1 = 1'b0; a1 = 32'h30;
        tick();
        v1 = 1'b0; v0 = 1'b1;
        tick();
        v0 = 1'b0;
        repeat (5) tick();
        // randomized traffic with occasional withdrawals and resets
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 199) == 0;
            if (!v0 && $urandom_range(0, 1) == 1) begin
                v0 = 1'b1; we0 = 1'($urandom_range(0, 1));
                a0 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; wd0 = $urandom;
            end else if (v0 && $urandom_range(0, 29) == 0) v0 = 1'b0;
            if (!v1 && $urandom_range(0, 1) == 1) begin
                v1 = 1'b1; we1 = 1'($urandom_range(0, 1));
                a1 = {26'd0, 4'($urandom_range(0, 15)), 2'b00}; wd1 = $urandom;
            end else if (v1 && $urandom_range(0, 29) == 0) v1 = 1'b0;
            tick();
            if (acc[0]) v0 = 1'b0;
            if (acc[1]) v1 = 1'b0;
        end
        rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
        // MEM_LATENCY=1: back-to-back reads of 0x0 then 0x4
        rdy_pat = 6'b001001; rv_pat = 6'b100100;
        s_rst = 1'b0; s_v = 1'b1; s_a = 32'd0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) s_a = 32'd4;
            if (c == 4) s_v = 1'b0;
            #1;
            chk("l1_ready", 32'(s_rdy), 32'(rdy_pat[c]));
            chk("l1_rvalid", 32'(s_rv), 32'(rv_pat[c]));
            chk("l1_write_en", 32'(s_mwe), 32'd0);
            if (rv_pat[c]) chk("l1_rdata", s_rd, c == 2 ? 32'hA : 32'hB);
            @(negedge clk);
        end
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
